// File: rtl/seq_multiplier.sv
// Multi-cycle shift-and-add multiplier: WIDTH iterations of add/shift, start/done handshake.
// Optional signed support is compiled in when MULT_SIGNED_EN is defined.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               Sign,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] P,
  output logic [1:0]         dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   h;
  logic [CW-1:0]      cnt;
  logic               accept;
  logic               last_iter;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   h_shift;
  logic [WIDTH-1:0]   q_shift;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] p_final;
  logic [WIDTH-1:0]   a_load;
  logic [WIDTH-1:0]   b_load;

  // Handshake: Start is a request sampled each rising edge; it is accepted only in
  // IDLE or DONE, Busy marks the WIDTH iteration cycles, Done is a one-cycle pulse.
  assign accept    = Start && ((state == IDLE) || (state == DONE));
  assign last_iter = (state == RUN) && (cnt == CNT_ONE);

  // The carry-out of the add lands in the top bit of H as {carry, H, Q} shifts right.
  always_comb begin
    sum = {1'b0, h};
    if (q[0]) sum = {1'b0, h} + {1'b0, m};
    h_shift = sum[WIDTH:1];
    q_shift = {sum[0], q[WIDTH-1:1]};
    product = {h_shift, q_shift};
  end

`ifdef MULT_SIGNED_EN
  logic neg;
  logic neg_load;

  // Magnitudes fit unsigned WIDTH bits, including the most-negative operand.
  always_comb begin
    a_load   = (Sign && A[WIDTH-1]) ? (~A + 1'b1) : A;
    b_load   = (Sign && B[WIDTH-1]) ? (~B + 1'b1) : B;
    neg_load = Sign && (A[WIDTH-1] ^ B[WIDTH-1]);
    p_final  = neg ? (~product + 1'b1) : product;
  end

  always_ff @(posedge clk) begin
    if (rst)         neg <= 1'b0;
    else if (accept) neg <= neg_load;
  end
`else
  logic unused_sign;

  assign unused_sign = Sign;

  always_comb begin
    a_load  = A;
    b_load  = B;
    p_final = product;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = Start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign Busy      = (state == RUN);
  assign Done      = (state == DONE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      m   <= '0;
      q   <= '0;
      h   <= '0;
      cnt <= '0;
      P   <= '0;
    end else if (accept) begin
      m   <= a_load;
      q   <= b_load;
      h   <= '0;
      cnt <= CNT_INIT;
    end else if (state == RUN) begin
      h   <= h_shift;
      q   <= q_shift;
      cnt <= cnt - CNT_ONE;
      // P only moves on the edge entering DONE.
      if (last_iter) P <= p_final;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: driver pushes expected products, a monitor checks
// every Done, latency, Busy length, P hold behaviour and reset state.
module tb_seq_multiplier;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           Start;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           Sign;
  logic           Busy;
  logic           Done;
  logic [2*W-1:0] P;
  logic [1:0]     dbg_state;

  logic [2*W-1:0] exp_q[$];
  int             lat_q[$];
  logic [2*W-1:0] p_model;
  logic           rst_d;
  int             cyc;
  int             run_len;
  int             checks;
  int             errors;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .Start     (Start),
    .A         (A),
    .B         (B),
    .Sign      (Sign),
    .Busy      (Busy),
    .Done      (Done),
    .P         (P),
    .dbg_state (dbg_state)
  );

  // Clock and reset-sample block
  always #5 clk = ~clk;

  initial begin
    cyc   = 0;
    rst_d = 1'b1;
  end

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst;
  end

  function automatic void chk(input string name, input logic [2*W-1:0] act,
                              input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Scoreboard monitor
  initial begin
    checks  = 0;
    errors  = 0;
    p_model = '0;
    run_len = 0;
    forever begin
      @(negedge clk);
      if (rst_d) begin
        chk("reset_busy", {63'd0, Busy}, 64'd0);
        chk("reset_done", {63'd0, Done}, 64'd0);
        chk("reset_p", P, 64'd0);
        exp_q.delete();
        lat_q.delete();
        p_model = '0;
        run_len = 0;
      end else begin
        chk("busy_done_exclusive", {63'd0, Busy & Done}, 64'd0);
        if (Done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
          end else begin
            p_model = exp_q.pop_front();
            chk("product", P, p_model);
            chk("latency", 64'(cyc - lat_q.pop_front()), 64'(W));
          end
        end else begin
          chk("p_hold", P, p_model);
        end
        if (Busy) begin
          run_len++;
        end else if (run_len != 0) begin
          chk("busy_length", 64'(run_len), 64'(W));
          run_len = 0;
        end
        if (exp_q.size() != 0 && (cyc - lat_q[0]) > 2 * W) begin
          chk("done_timeout", 64'd0, 64'd1);
          void'(exp_q.pop_front());
          void'(lat_q.pop_front());
        end
      end
    end
  end

  // Driver tasks
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [2*W-1:0] exp);
    @(posedge clk);
    #1;
    A     = a;
    B     = b;
    Sign  = s;
    Start = 1'b1;
    exp_q.push_back(exp);
    lat_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    Start = 1'b0;
    A     = W'($urandom);
    B     = W'($urandom);
    Sign  = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 4 * W; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                     input logic [2*W-1:0] exp);
    issue(a, b, s, exp);
    wait_empty();
  endtask

  initial begin
    rst   = 1'b1;
    Start = 1'b0;
    A     = '0;
    B     = '0;
    Sign  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);

    mul(32'h0000_0007, 32'h0000_0006, 1'b0, 64'h0000_0000_0000_002A);
    mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    mul(32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 64'h0);

    // Start pulse during Busy must be ignored
    issue(32'h0000_1234, 32'h0000_0010, 1'b0, 64'h0000_0000_0001_2340);
    repeat (10) @(posedge clk);
    #1;
    A     = 32'd5;
    B     = 32'd5;
    Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    wait_empty();

    // Start held high: back-to-back operations, operands scrambled during RUN
    @(posedge clk);
    #1;
    A     = 32'd3;
    B     = 32'd5;
    Sign  = 1'b0;
    Start = 1'b1;
    exp_q.push_back(64'h0000_0000_0000_000F);
    lat_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    A = 32'h0001_0000;
    B = 32'h0001_0000;
    exp_q.push_back(64'h0000_0001_0000_0000);
    lat_q.push_back(cyc + W + 1);
    repeat (W + 1) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      A = W'($urandom);
      B = W'($urandom);
      @(posedge clk);
      #1;
    end
    Start = 1'b0;
    wait_empty();

`ifdef MULT_SIGNED_EN
    mul(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
    mul(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    mul(32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, 64'h0000_0000_0000_000F);
    mul(32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000);
    mul(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0);
`else
    mul(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 64'h0000_0004_FFFF_FFF1);
    mul(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    mul(32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, 64'hFFFF_FFF8_0000_000F);
    mul(32'h8000_0000, 32'h0000_0001, 1'b1, 64'h0000_0000_8000_0000);
    mul(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0);
`endif
    mul(32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 64'h0000_0004_FFFF_FFF1);

    // Reset mid-RUN: the aborted operation must never produce Done
    issue(32'h0000_00FF, 32'h0000_00FF, 1'b0, 64'h0000_0000_0000_FE01);
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2 * W) @(posedge clk);

    mul(32'h0000_0010, 32'h0000_0010, 1'b0, 64'h0000_0000_0000_0100);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, checks %0d errors %0d",
             checks, errors);
    $fatal(1, "timeout");
  end

endmodule
